scan_state_reg: RTL and testbench

- State-register stage directly upstream and downstream of the next-state combinational block.
- Drives present-state bits y into that block; registers its next-state outputs Y back each cycle.
- In test mode it is a scan chain with a built-in shift/capture/unload sequencer. A tester can load any present state, capture one combinational evaluation, and shift the result out serially.

---
 rtl/scan_pkg.sv | 19 +
 rtl/scan_misr.sv | 42 ++++
 rtl/scan_state_reg.sv | 116 +++++++++++
 tb/tb_scan_state_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan state register and its optional MISR.
// The MISR itself is only built when SCAN_MISR_EN is defined.
package scan_pkg;

    localparam int unsigned STATE_W_DEF = 2;
    localparam int unsigned CNT_W_DEF   = 2;

    // Feedback taps: MSB folds back into bit 0 and bit 1.
    localparam int unsigned MISR_TAP = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } scan_fsm_e;

endpackage

// File: rtl/scan_misr.sv
// Multiple-input signature register compacting the serial unload stream.
// Instantiated by scan_state_reg only when SCAN_MISR_EN is defined.
module scan_misr
    import scan_pkg::*;
#(
    parameter int unsigned STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic               din,
    output logic [STATE_W-1:0] signature
);

    localparam logic [STATE_W-1:0] TAP = STATE_W'(MISR_TAP);

    logic [STATE_W-1:0] sig_q;
    logic [STATE_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[STATE_W-2:0], 1'b0}
                  ^ (sig_q[STATE_W-1] ? TAP : '0)
                  ^ {{(STATE_W-1){1'b0}}, din};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/scan_state_reg.sv
// Present-state register with a built-in load/capture/unload scan sequencer.
// Define SCAN_MISR_EN to add the misr_clr input and signature output.
module scan_state_reg
    import scan_pkg::*;
#(
    parameter int unsigned STATE_W = STATE_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] next_state,
    output logic [STATE_W-1:0] state,
    input  logic               test_mode,
    input  logic               scan_start,
    input  logic               scan_in,
    output logic               scan_out,
`ifdef SCAN_MISR_EN
    input  logic               misr_clr,
    output logic [STATE_W-1:0] signature,
`endif
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STATE_W - 1);

    scan_fsm_e          fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               shift_en;

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        shift_en = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (!test_mode) begin
                    state_d = next_state;
                end else if (scan_start) begin
                    fsm_d = S_SHIFT_IN;
                    cnt_d = '0;
                end
            end
            S_SHIFT_IN: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) fsm_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = next_state;
                fsm_d   = S_SHIFT_OUT;
                cnt_d   = '0;
            end
            S_SHIFT_OUT: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) fsm_d = S_DONE;
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        if (shift_en) begin
            state_d = {state_q[STATE_W-2:0], scan_in};
        end

        // Leaving test mode mid-sequence aborts without touching the state flops.
        if (fsm_q != S_IDLE && !test_mode) begin
            fsm_d    = S_IDLE;
            cnt_d    = cnt_q;
            state_d  = state_q;
            shift_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state    = state_q;
    assign scan_out = state_q[STATE_W-1];
    assign busy     = (fsm_q == S_SHIFT_IN) || (fsm_q == S_CAPTURE) || (fsm_q == S_SHIFT_OUT);
    assign done     = (fsm_q == S_DONE);

`ifdef SCAN_MISR_EN
    logic unload_en;
    assign unload_en = shift_en && (fsm_q == S_SHIFT_OUT);

    scan_misr #(
        .STATE_W (STATE_W)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (misr_clr),
        .en        (unload_en),
        .din       (scan_out),
        .signature (signature)
    );
`endif

endmodule

// File: tb/tb_scan_state_reg.sv
// Directed bench for scan_state_reg: cycle table plus abort/reset/MISR sequences.
// Compile with SCAN_MISR_EN defined to exercise the signature output.
module tb_scan_state_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] next_state;
    logic [1:0] state;
    logic       test_mode;
    logic       scan_start;
    logic       scan_in;
    logic       scan_out;
    logic       busy;
    logic       done;
`ifdef SCAN_MISR_EN
    logic       misr_clr;
    logic [1:0] signature;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scan_state_reg #(
        .STATE_W (2),
        .CNT_W   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_state (next_state),
        .state      (state),
        .test_mode  (test_mode),
        .scan_start (scan_start),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
`ifdef SCAN_MISR_EN
        .misr_clr   (misr_clr),
        .signature  (signature),
`endif
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic       rst_n;
        logic       test_mode;
        logic       scan_start;
        logic       scan_in;
        logic [1:0] next_state;
        logic [1:0] exp_state;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic tm, input logic ss, input logic si,
                       input logic [1:0] ns, input logic [1:0] es, input logic eb,
                       input logic ed);
        vec_t v;
        v.rst_n = r; v.test_mode = tm; v.scan_start = ss; v.scan_in = si;
        v.next_state = ns; v.exp_state = es; v.exp_busy = eb; v.exp_done = ed;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] es, input logic eb,
                              input logic ed);
        check({tag, ".state"},    32'(state),    32'(es));
        check({tag, ".scan_out"}, 32'(scan_out), 32'(es[1]));
        check({tag, ".busy"},     32'(busy),     32'(eb));
        check({tag, ".done"},     32'(done),     32'(ed));
    endtask

`ifdef SCAN_MISR_EN
    logic [1:0] sig_model = 2'b00;

    function automatic logic [1:0] misr_next(input logic [1:0] s, input logic d);
        logic m;
        m = s[1];
        return {s[0] ^ m, m ^ d};
    endfunction

    // Full load/capture/unload from IDLE; scan_out and MISR model tracked per unload edge.
    task automatic run_misr_seq(input logic [1:0] load, input logic [1:0] cap);
        logic [1:0] st;
        test_mode = 1'b1; scan_start = 1'b1; scan_in = 1'b0; next_state = 2'b00;
        step();
        scan_start = 1'b0;
        check("misr_seq.busy_start", 32'(busy), 32'd1);
        scan_in = load[1]; step();
        scan_in = load[0]; step();
        check("misr_seq.loaded", 32'(state), 32'(load));
        next_state = cap; step();
        st = cap;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("misr_seq.unload%0d", i), 32'(scan_out), 32'(st[1]));
            check($sformatf("misr_seq.busy%0d", i), 32'(busy), 32'd1);
            sig_model = misr_next(sig_model, st[1]);
            scan_in = 1'b0;
            st = {st[0], 1'b0};
            step();
        end
        check("misr_seq.done_cycle6", 32'(done), 32'd1);
        check("misr_seq.busy_done",   32'(busy), 32'd0);
        step();
        check("misr_seq.done_drop",   32'(done), 32'd0);
    endtask
`endif

    initial begin
        rst_n = 1'b0; test_mode = 1'b0; scan_start = 1'b0; scan_in = 1'b0;
        next_state = 2'b11;
`ifdef SCAN_MISR_EN
        misr_clr = 1'b0;
`endif

        //  rst tm ss si  ns     state  busy done
        add(0, 0, 0, 0, 2'b11, 2'b00, 0, 0);   // reset
        add(0, 0, 0, 0, 2'b11, 2'b00, 0, 0);
        add(1, 0, 0, 0, 2'b10, 2'b10, 0, 0);   // functional
        add(1, 0, 0, 0, 2'b01, 2'b01, 0, 0);
        add(1, 0, 1, 0, 2'b01, 2'b01, 0, 0);   // scan_start ignored in functional mode
        add(1, 1, 0, 0, 2'b11, 2'b01, 0, 0);   // test mode, IDLE holds
        add(1, 1, 1, 0, 2'b00, 2'b01, 1, 0);   // scan_start -> SHIFT_IN
        add(1, 1, 0, 0, 2'b00, 2'b10, 1, 0);   // load 0
        add(1, 1, 0, 0, 2'b00, 2'b00, 1, 0);   // load 0
        add(1, 1, 0, 0, 2'b10, 2'b10, 1, 0);   // capture 10
        add(1, 1, 0, 0, 2'b00, 2'b00, 1, 0);   // unload 1
        add(1, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // unload 0, DONE (cycle 6)
        add(1, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // back to IDLE
        add(1, 1, 1, 0, 2'b00, 2'b00, 1, 0);   // second sequence
        add(1, 1, 0, 1, 2'b00, 2'b01, 1, 0);
        add(1, 1, 0, 1, 2'b00, 2'b11, 1, 0);
        add(1, 1, 0, 0, 2'b11, 2'b11, 1, 0);   // capture 11
        add(1, 1, 0, 0, 2'b00, 2'b10, 1, 0);   // unload 1, overlap 0
        add(1, 1, 0, 1, 2'b00, 2'b01, 0, 1);   // unload 1, overlap 1
        add(1, 1, 0, 0, 2'b10, 2'b01, 0, 0);
        add(1, 0, 0, 0, 2'b10, 2'b10, 0, 0);   // functional again

        foreach (vq[i]) begin
            rst_n = vq[i].rst_n; test_mode = vq[i].test_mode;
            scan_start = vq[i].scan_start; scan_in = vq[i].scan_in;
            next_state = vq[i].next_state;
            step();
            check_outs($sformatf("vec%0d", i), vq[i].exp_state, vq[i].exp_busy, vq[i].exp_done);
        end

        // Abort during SHIFT_IN: state holds that edge, functional update on the next.
        test_mode = 1'b1; scan_start = 1'b1; scan_in = 1'b0; next_state = 2'b00;
        step();
        scan_start = 1'b0; scan_in = 1'b1;
        step();
        check_outs("abort.shift", 2'b01, 1'b1, 1'b0);
        test_mode = 1'b0; next_state = 2'b11;
        step();
        check_outs("abort.edge", 2'b01, 1'b0, 1'b0);
        step();
        check_outs("abort.resume", 2'b11, 1'b0, 1'b0);
        step();
        check("abort.no_done", 32'(done), 32'd0);

        // Reset during SHIFT_OUT.
        test_mode = 1'b1; scan_start = 1'b1;
        step();
        scan_start = 1'b0; scan_in = 1'b1; step(); step();
        next_state = 2'b10; step();
        check_outs("rst_mid.capture", 2'b10, 1'b1, 1'b0);
        step();
        check_outs("rst_mid.unload", 2'b01, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        check_outs("rst_mid.reset", 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_outs("rst_mid.idle_hold", 2'b00, 1'b0, 1'b0);
        test_mode = 1'b0; next_state = 2'b01;
        step();
        check_outs("rst_mid.functional", 2'b01, 1'b0, 1'b0);

`ifdef SCAN_MISR_EN
        misr_clr = 1'b1;
        step();
        misr_clr = 1'b0;
        sig_model = 2'b00;
        check("misr.cleared", 32'(signature), 32'(sig_model));
        run_misr_seq(2'b00, 2'b10);
        check("misr.after_10", 32'(signature), 32'(sig_model));
        run_misr_seq(2'b11, 2'b11);
        check("misr.after_11", 32'(signature), 32'(sig_model));
        check("misr.ref_const", 32'(signature), 32'h2);
        test_mode = 1'b0; next_state = 2'b11;
        step(); step();
        check("misr.hold_idle", 32'(signature), 32'(sig_model));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
